blink_decoder: RTL and testbench

Measures the toggle rate of a slow square-wave input, such as a blinking LED line or a board test point, driven by another block or an external board. The input is asynchronous to `clk`. The block synchronises it, detects both edges and reports each half-period in `clk` cycles. It declares lock after repeated consistent measurements and flags loss of signal when no edge arrives in time. It is the receiving end for the team's LED blink generators and is used for self-check and board bring-up on the 5 MHz `clk` domain.

---
 rtl/blink_decoder.sv | 72 +++++++
 tb/tb_blink_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/blink_decoder.sv
// blink_decoder: measures half-periods of an asynchronous square wave, flags lock and loss of signal
module blink_decoder #(
   parameter int CNT_W      = 24,
   parameter int TIMEOUT    = 6_000_000,
   parameter int TOL        = 16,
   parameter int LOCK_COUNT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   output logic             level,
   output logic [CNT_W-1:0] half_period,
   output logic             period_valid,
   output logic             locked,
   output logic             no_signal
);
   typedef enum logic {IDLE, MEASURE} state_t;
   state_t           state;
   logic             s1, s2, s3;
   logic             edge_det, prev_valid, match;
   logic [CNT_W-1:0] cnt, prev, diff;
   logic [3:0]       match_cnt, match_nxt;
   assign edge_det  = s2 ^ s3;
   assign level     = s3;
   assign diff      = cnt >= prev ? cnt - prev : prev - cnt;
   assign match     = prev_valid && diff <= CNT_W'(TOL);
   assign match_nxt = !match ? 4'd0 : match_cnt == 4'(LOCK_COUNT) ? match_cnt : match_cnt + 4'd1;
   always_ff @(posedge clk) begin
      if (rst) begin
         {s1, s2, s3} <= 3'b000;
         state        <= IDLE;
         cnt          <= '0;
         prev         <= '0;
         half_period  <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         no_signal    <= 1'b0;
         match_cnt    <= 4'd0;
         prev_valid   <= 1'b0;
      end else begin
         {s1, s2, s3} <= {sig_in, s1, s2};
         period_valid <= 1'b0;
         if (state == IDLE) begin
            cnt <= edge_det ? CNT_W'(1) : '0;
            if (edge_det) begin
               state      <= MEASURE;
               prev_valid <= 1'b0;
               no_signal  <= 1'b0;
            end
         end else if (edge_det) begin
            // an edge landing on the timeout cycle is still a valid measurement
            half_period  <= cnt;
            period_valid <= 1'b1;
            cnt          <= CNT_W'(1);
            match_cnt    <= match_nxt;
            locked       <= match_nxt == 4'(LOCK_COUNT);
            prev         <= cnt;
            prev_valid   <= 1'b1;
            no_signal    <= 1'b0;
         end else if (cnt == CNT_W'(TIMEOUT)) begin
            state      <= IDLE;
            cnt        <= '0;
            no_signal  <= 1'b1;
            locked     <= 1'b0;
            match_cnt  <= 4'd0;
            prev_valid <= 1'b0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_blink_decoder.sv
// tb_blink_decoder: table vectors, corner sequences and random toggling against an elapsed-time model
module tb_blink_decoder;
   logic        clk = 1'b0, rst = 1'b1, sig_in = 1'b0;
   logic        level_a, pv_a, lk_a, ns_a, level_b, pv_b, lk_b, ns_b;
   logic [23:0] hp_a;
   logic [15:0] hp_b;
   int          checks = 0, failures = 0;
   localparam int LC = 2;

   always #5 clk = ~clk;

   blink_decoder dut_a (
      .clk(clk), .rst(rst), .sig_in(sig_in), .level(level_a), .half_period(hp_a),
      .period_valid(pv_a), .locked(lk_a), .no_signal(ns_a));

   blink_decoder #(.CNT_W(16), .TIMEOUT(100), .TOL(2), .LOCK_COUNT(LC)) dut_b (
      .clk(clk), .rst(rst), .sig_in(sig_in), .level(level_b), .half_period(hp_b),
      .period_valid(pv_b), .locked(lk_b), .no_signal(ns_b));

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // reference: edges are timestamps, half-period is elapsed time between them
   typedef struct {
      bit     active;
      longint last;
      bit     have_prev;
      longint prevhp;
      int     streak;
      bit     lk;
      bit     ns;
      longint hp;
      bit     pv;
   } mst_t;
   mst_t   m [2];
   bit [3:0] sh;
   longint cyc = 0;
   logic   s_in, s_rst;

   function automatic longint to_of(input int i);
      return i == 1 ? 64'd100 : 64'd6000000;
   endfunction

   function automatic longint tol_of(input int i);
      return i == 1 ? 64'd2 : 64'd16;
   endfunction

   task automatic model_step(input int i, input bit e);
      longint d, ad;
      m[i].pv = 1'b0;
      if (e && !m[i].active) begin
         m[i].active    = 1'b1;
         m[i].last      = cyc;
         m[i].have_prev = 1'b0;
         m[i].ns        = 1'b0;
      end else if (e) begin
         d  = cyc - m[i].last;
         ad = d > m[i].prevhp ? d - m[i].prevhp : m[i].prevhp - d;
         m[i].streak    = (m[i].have_prev && ad <= tol_of(i)) ? (m[i].streak < LC ? m[i].streak + 1 : LC) : 0;
         m[i].lk        = m[i].streak == LC;
         m[i].hp        = d;
         m[i].pv        = 1'b1;
         m[i].prevhp    = d;
         m[i].have_prev = 1'b1;
         m[i].last      = cyc;
         m[i].ns        = 1'b0;
      end else if (m[i].active && cyc - m[i].last == to_of(i)) begin
         m[i].ns        = 1'b1;
         m[i].lk        = 1'b0;
         m[i].streak    = 0;
         m[i].have_prev = 1'b0;
         m[i].active    = 1'b0;
      end
   endtask

   always begin
      @(posedge clk);
      s_in  = sig_in;
      s_rst = rst;
      #1;
      cyc++;
      if (s_rst) begin
         sh   = '0;
         m[0] = '{default: 0};
         m[1] = '{default: 0};
      end else begin
         sh = {sh[2:0], s_in};
         for (int i = 0; i < 2; i++) model_step(i, sh[2] ^ sh[3]);
      end
      chk("model_level_a", level_a, sh[2]);
      chk("model_hp_a", hp_a, m[0].hp);
      chk("model_pv_a", pv_a, m[0].pv);
      chk("model_locked_a", lk_a, m[0].lk);
      chk("model_nosig_a", ns_a, m[0].ns);
      chk("model_level_b", level_b, sh[2]);
      chk("model_hp_b", hp_b, m[1].hp);
      chk("model_pv_b", pv_b, m[1].pv);
      chk("model_locked_b", lk_b, m[1].lk);
      chk("model_nosig_b", ns_b, m[1].ns);
   end

   bit     cap_pva, cap_pvb, cap_la, cap_lb, cap_nsb;
   longint cap_hpa, cap_hpb;

   // toggle, then hold for `hold` cycles; outputs for this edge are captured two cycles in
   task automatic pulse(input int hold);
      @(negedge clk);
      sig_in = ~sig_in;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         if (i == 2) begin
            cap_pva = pv_a; cap_pvb = pv_b; cap_hpa = hp_a; cap_hpb = hp_b;
            cap_la  = lk_a; cap_lb  = lk_b; cap_nsb = ns_b;
         end
      end
   endtask

   typedef struct {
      int     hold;
      bit     pv;
      longint hp;
      bit     la;
      bit     lb;
   } vec_t;
   vec_t tbl [9];

   initial begin
      int pvc, n;
      tbl[0] = '{10, 1'b0,  0, 1'b0, 1'b0};
      tbl[1] = '{10, 1'b1, 10, 1'b0, 1'b0};
      tbl[2] = '{10, 1'b1, 10, 1'b0, 1'b0};
      tbl[3] = '{12, 1'b1, 10, 1'b1, 1'b1};
      tbl[4] = '{13, 1'b1, 12, 1'b1, 1'b1};
      tbl[5] = '{20, 1'b1, 13, 1'b1, 1'b1};
      tbl[6] = '{20, 1'b1, 20, 1'b1, 1'b0};
      tbl[7] = '{20, 1'b1, 20, 1'b1, 1'b0};
      tbl[8] = '{ 5, 1'b1, 20, 1'b1, 1'b1};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_level", level_a, 0);
      chk("rst_hp_a", hp_a, 0);
      chk("rst_hp_b", hp_b, 0);
      chk("rst_pv", pv_a | pv_b, 0);
      chk("rst_locked", lk_a | lk_b, 0);
      chk("rst_nosig", ns_a | ns_b, 0);
      @(negedge clk);
      rst = 1'b0;
      pvc = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         pvc += int'(pv_a) + int'(pv_b);
      end
      chk("quiet_50_pv", pvc, 0);
      for (int k = 0; k < 9; k++) begin
         pulse(tbl[k].hold);
         chk($sformatf("tbl%0d_pv_a", k), cap_pva, tbl[k].pv);
         chk($sformatf("tbl%0d_pv_b", k), cap_pvb, tbl[k].pv);
         chk($sformatf("tbl%0d_hp_a", k), cap_hpa, tbl[k].hp);
         chk($sformatf("tbl%0d_hp_b", k), cap_hpb, tbl[k].hp);
         chk($sformatf("tbl%0d_lk_a", k), cap_la, tbl[k].la);
         chk($sformatf("tbl%0d_lk_b", k), cap_lb, tbl[k].lb);
      end
      n = 0;
      while (!ns_b && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("timeout_delay", n + 2, 100);
      chk("timeout_hp_kept", hp_b, 20);
      chk("timeout_unlock", lk_b, 0);
      pulse(10);
      chk("resume_nosig_clear", cap_nsb, 0);
      chk("resume_idle_no_pv", cap_pvb, 0);
      pulse(10);
      pulse(10);
      chk("relock_not_yet", cap_lb, 0);
      pulse(100);
      chk("relock_4th_edge", cap_lb, 1);
      pulse(10);
      chk("collision_hp", cap_hpb, 100);
      chk("collision_pv", cap_pvb, 1);
      chk("collision_nosig", cap_nsb, 0);
      pulse(10);
      pulse(10);
      pulse(10);
      chk("locked_before_rst", cap_lb, 1);
      @(negedge clk);
      sig_in = 1'b1;
      rst    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_hp", hp_a | 24'(hp_b), 0);
      chk("midrst_locked", lk_a | lk_b, 0);
      chk("midrst_pv_ns", pv_a | pv_b | ns_a | ns_b, 0);
      chk("midrst_level", level_a | level_b, 0);
      @(negedge clk);
      rst = 1'b0;
      pvc = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         pvc += int'(pv_a) + int'(pv_b);
      end
      chk("postrst_idle_edge_no_pv", pvc, 0);
      chk("postrst_level", level_b, 1);
      for (int b = 0; b < 60; b++) begin
         int base, len;
         if ($urandom_range(0, 9) == 0) begin
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
         base = $urandom_range(1, 40);
         len  = $urandom_range(2, 8);
         for (int j = 0; j < len; j++) pulse(base + int'($urandom_range(0, 3)));
         if ($urandom_range(0, 3) == 0) pulse($urandom_range(95, 130));
      end
      repeat (5) @(posedge clk);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
